// File: rtl/ucsbece154_icache_pkg.sv
// Shared definitions for the two-way instruction cache: default geometry,
// derived address-field widths and the controller state encoding.
package ucsbece154_icache_pkg;

   localparam int NUM_SETS_DEF    = 8;
   localparam int NUM_WAYS        = 2;
   localparam int BLOCK_WORDS_DEF = 4;

   localparam int OFF_W = $clog2(BLOCK_WORDS_DEF);
   localparam int IDX_W = $clog2(NUM_SETS_DEF);
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ucsbece154_icache_if.sv
// Fetch-side and instruction-memory-side signals of the cache, bundled.
// slave is the cache's view; master is the fetch stage plus memory.
interface ucsbece154_icache_if;

   logic        ReadEnable;
   logic [31:0] ReadAddress;
   logic [31:0] Instruction;
   logic        Ready;
   logic        MemReadRequest;
   logic [31:0] MemReadAddress;
   logic [31:0] MemDataIn;
   logic        MemDataReady;

   modport slave (
      input  ReadEnable, ReadAddress, MemDataIn, MemDataReady,
      output Instruction, Ready, MemReadRequest, MemReadAddress
   );

   modport master (
      output ReadEnable, ReadAddress, MemDataIn, MemDataReady,
      input  Instruction, Ready, MemReadRequest, MemReadAddress
   );

endinterface

// File: rtl/ucsbece154_icache_way.sv
// One way of the cache: valid/tag/data arrays with a combinational read
// port and a whole-line install port.
module ucsbece154_icache_way #(
   parameter int NUM_SETS    = 8,
   parameter int BLOCK_WORDS = 4,
   parameter int TAG_BITS    = 25
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [$clog2(NUM_SETS)-1:0]       rd_idx,
   input  logic [$clog2(BLOCK_WORDS)-1:0]    rd_off,
   input  logic [TAG_BITS-1:0]               rd_tag,
   output logic                              hit,
   output logic [31:0]                       word,
   input  logic                              wr_en,
   input  logic [$clog2(NUM_SETS)-1:0]       wr_idx,
   input  logic [TAG_BITS-1:0]               wr_tag,
   input  logic [BLOCK_WORDS-1:0][31:0]      wr_line
);

   logic [NUM_SETS-1:0]             valid_q;
   logic [TAG_BITS-1:0]             tag_q  [NUM_SETS];
   logic [BLOCK_WORDS-1:0][31:0]    data_q [NUM_SETS];

   // Valid bits are the only per-way state cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_line;
      end
   end

   // Read port is purely combinational so hits return in the same cycle.
   always_comb begin
      hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      word = data_q[rd_idx][rd_off];
   end

endmodule

// File: rtl/ucsbece154_icache.sv
// Two-way set-associative read-only instruction cache. Hits return in the
// same cycle; misses stall fetch, burst-fill the LRU way, then answer from
// the newly installed line in a one-cycle DONE state.
//
// state | meaning
// IDLE  | serve hits combinationally; a miss latches the address
// FETCH | burst request active, collect BLOCK_WORDS beats
// DONE  | answer from the freshly installed line, then back to IDLE
module ucsbece154_icache
   import ucsbece154_icache_pkg::*;
#(
   parameter int NUM_SETS    = NUM_SETS_DEF,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   ucsbece154_icache_if.slave   bus
);

   localparam int OFF_BITS = $clog2(BLOCK_WORDS);
   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS - 2;

   state_t                       state_q, state_d;
   logic [TAG_BITS-1:0]          lat_tag_q;
   logic [IDX_BITS-1:0]          lat_idx_q;
   logic [OFF_BITS-1:0]          lat_off_q;
   logic                         victim_q;
   logic [OFF_BITS-1:0]          cnt_q;
   logic [BLOCK_WORDS-1:0][31:0] line_q;
   logic [BLOCK_WORDS-1:0][31:0] fill_line;
   logic [NUM_SETS-1:0]          lru_q;

   logic [TAG_BITS-1:0]          pc_tag, rd_tag;
   logic [IDX_BITS-1:0]          pc_idx, rd_idx;
   logic [OFF_BITS-1:0]          pc_off, rd_off;

   logic [NUM_WAYS-1:0]          way_hit;
   logic [31:0]                  way_word [NUM_WAYS];
   logic                         hit_any, hit_way, install;

   logic                         ready, mem_req;
   logic [31:0]                  instr, mem_addr;
   logic                         unused_addr_bits;

   assign pc_tag = bus.ReadAddress[31 -: TAG_BITS];
   assign pc_idx = bus.ReadAddress[OFF_BITS+2 +: IDX_BITS];
   assign pc_off = bus.ReadAddress[2 +: OFF_BITS];
   assign unused_addr_bits = ^bus.ReadAddress[1:0];

   // Outside IDLE the ways are read at the latched miss address.
   assign rd_tag = (state_q == IDLE) ? pc_tag : lat_tag_q;
   assign rd_idx = (state_q == IDLE) ? pc_idx : lat_idx_q;
   assign rd_off = (state_q == IDLE) ? pc_off : lat_off_q;

   assign hit_any = |way_hit;
   assign hit_way = way_hit[0] ? 1'b0 : 1'b1;
   assign install = (state_q == FETCH) && bus.MemDataReady &&
                    (cnt_q == OFF_BITS'(BLOCK_WORDS - 1));

   // The final beat bypasses the line buffer straight into the victim way.
   always_comb begin
      fill_line        = line_q;
      fill_line[cnt_q] = bus.MemDataIn;
   end

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      ucsbece154_icache_way #(
         .NUM_SETS    (NUM_SETS),
         .BLOCK_WORDS (BLOCK_WORDS),
         .TAG_BITS    (TAG_BITS)
      ) u_way (
         .clk     (clk),
         .reset   (reset),
         .rd_idx  (rd_idx),
         .rd_off  (rd_off),
         .rd_tag  (rd_tag),
         .hit     (way_hit[w]),
         .word    (way_word[w]),
         .wr_en   (install && (victim_q == 1'(w))),
         .wr_idx  (lat_idx_q),
         .wr_tag  (lat_tag_q),
         .wr_line (fill_line)
      );
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and output decode.
   always_comb begin
      state_d  = state_q;
      ready    = 1'b0;
      instr    = '0;
      mem_req  = 1'b0;
      mem_addr = '0;
      case (state_q)
         IDLE: begin
            if (bus.ReadEnable) begin
               if (hit_any) begin
                  ready = 1'b1;
                  instr = way_word[hit_way];
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = {lat_tag_q, lat_idx_q, {(OFF_BITS+2){1'b0}}};
            if (install) state_d = DONE;
         end
         DONE: begin
            ready   = bus.ReadEnable;
            instr   = bus.ReadEnable ? way_word[victim_q] : '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.Ready          = ready;
   assign bus.Instruction    = instr;
   assign bus.MemReadRequest = mem_req;
   assign bus.MemReadAddress = mem_addr;

   // Miss bookkeeping: latched address, victim choice, beat counter, LRU.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_tag_q <= '0;
         lat_idx_q <= '0;
         lat_off_q <= '0;
         victim_q  <= 1'b0;
         cnt_q     <= '0;
         lru_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ReadEnable) begin
                  if (hit_any) begin
                     lru_q[pc_idx] <= ~hit_way;
                  end else begin
                     lat_tag_q <= pc_tag;
                     lat_idx_q <= pc_idx;
                     lat_off_q <= pc_off;
                     victim_q  <= lru_q[pc_idx];
                     cnt_q     <= '0;
                  end
               end
            end
            FETCH: begin
               if (bus.MemDataReady) begin
                  if (install) begin
                     cnt_q            <= '0;
                     lru_q[lat_idx_q] <= ~victim_q;
                  end else begin
                     cnt_q <= cnt_q + OFF_BITS'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Line buffer collects the leading beats of a burst.
   always_ff @(posedge clk) begin
      if ((state_q == FETCH) && bus.MemDataReady) begin
         line_q[cnt_q] <= bus.MemDataIn;
      end
   end

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Directed and randomized check of the instruction cache against a
// recency-ordered set model and a synthetic instruction memory.
module tb_ucsbece154_icache;

   localparam int NSETS = 8;
   localparam int NWAYS = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ucsbece154_icache_if bus();

   ucsbece154_icache dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Per set: resident block addresses, most recently used first.
   logic [31:0] lines [NSETS][$];

   bit pat [7] = '{1, 0, 1, 0, 0, 1, 1};

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w[31:4] == 28'h0001000) return 32'hA0 + {28'h0, w[3:0]} / 4;
      return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   function automatic int set_of(input logic [31:0] a);
      return int'(a[6:4]);
   endfunction

   function automatic int find_line(input logic [31:0] a);
      int s;
      s = set_of(a);
      for (int i = 0; i < lines[s].size(); i++)
         if (lines[s][i] == (a >> 4)) return i;
      return -1;
   endfunction

   task automatic model_touch(input logic [31:0] a);
      int s, p;
      s = set_of(a);
      p = find_line(a);
      lines[s].delete(p);
      lines[s].push_front(a >> 4);
   endtask

   task automatic model_fill(input logic [31:0] a);
      int s;
      s = set_of(a);
      lines[s].push_front(a >> 4);
      if (lines[s].size() > NWAYS) void'(lines[s].pop_back());
   endtask

   task automatic model_clear();
      for (int s = 0; s < NSETS; s++) lines[s].delete();
   endtask

   // One fetch: hit or full miss service. mode 0 = random beat gaps,
   // mode 1 = fixed 1,0,1,0,0,1,1 DataReady pattern.
   task automatic access(input logic [31:0] a, input bit drop_en, input bit mode);
      logic [31:0] blk;
      int beats, step, lat;
      bit en, dr;
      blk = {a[31:4], 4'h0};
      bus.ReadEnable   = 1'b1;
      bus.ReadAddress  = a;
      bus.MemDataReady = 1'b0;
      @(negedge clk);
      if (find_line(a) >= 0) begin
         check32("hit_ready", 32'(bus.Ready), 32'd1);
         check32("hit_instr", bus.Instruction, mem_word(a));
         check32("hit_noreq", 32'(bus.MemReadRequest), 32'd0);
         @(posedge clk); #1;
         model_touch(a);
         bus.ReadEnable = 1'b0;
         return;
      end
      check32("miss_ready", 32'(bus.Ready), 32'd0);
      check32("miss_instr", bus.Instruction, 32'd0);
      check32("miss_setup_noreq", 32'(bus.MemReadRequest), 32'd0);
      @(posedge clk); #1;
      en    = 1'b1;
      beats = 0;
      step  = 0;
      lat   = $urandom_range(0, 2);
      while (beats < 4) begin
         if (mode) dr = pat[step];
         else if (step >= 20) dr = 1'b1;
         else dr = (step >= lat) && ($urandom_range(0, 2) != 0);
         if (drop_en && step == 1) begin
            en = 1'b0;
            bus.ReadEnable = 1'b0;
         end
         bus.MemDataReady = dr;
         bus.MemDataIn    = dr ? mem_word(blk + 32'(beats * 4)) : 32'hDEADBEEF;
         @(negedge clk);
         check32("fetch_req", 32'(bus.MemReadRequest), 32'd1);
         check32("fetch_addr", bus.MemReadAddress, blk);
         check32("fetch_stall", 32'(bus.Ready), 32'd0);
         @(posedge clk); #1;
         if (dr) beats++;
         step++;
      end
      bus.MemDataReady = 1'b0;
      bus.MemDataIn    = 32'h0;
      model_fill(a);
      @(negedge clk);
      check32("done_ready", 32'(bus.Ready), 32'(en));
      check32("done_instr", bus.Instruction, en ? mem_word(a) : 32'd0);
      check32("done_noreq", 32'(bus.MemReadRequest), 32'd0);
      @(posedge clk); #1;
      bus.ReadEnable = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      bus.ReadEnable   = 1'b0;
      bus.ReadAddress  = 32'h0;
      bus.MemDataIn    = 32'h0;
      bus.MemDataReady = 1'b0;
      model_clear();

      #2 reset = 1'b0;
      @(negedge clk);
      check32("rst_ready", 32'(bus.Ready), 32'd0);
      check32("rst_instr", bus.Instruction, 32'd0);
      check32("rst_req", 32'(bus.MemReadRequest), 32'd0);
      check32("rst_addr", bus.MemReadAddress, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Cold miss then same-line hits.
      check32("cold_is_miss", 32'(find_line(32'h00010000)), 32'hFFFFFFFF);
      access(32'h00010000, 1'b0, 1'b0);
      access(32'h00010004, 1'b0, 1'b0);
      access(32'h00010008, 1'b0, 1'b0);
      access(32'h0001000C, 1'b0, 1'b0);

      // LRU replacement within set 0.
      access(32'h00010080, 1'b0, 1'b0);
      access(32'h00010000, 1'b0, 1'b0);
      access(32'h00010100, 1'b0, 1'b0);
      access(32'h00010000, 1'b0, 1'b0);
      check32("evicted_is_miss", 32'(find_line(32'h00010080)), 32'hFFFFFFFF);
      access(32'h00010080, 1'b0, 1'b0);

      // Push 0x10000 out, then refill it with a gappy burst at offset 2.
      access(32'h00010180, 1'b0, 1'b0);
      check32("gap_is_miss", 32'(find_line(32'h00010008)), 32'hFFFFFFFF);
      access(32'h00010008, 1'b0, 1'b1);
      access(32'h00010000, 1'b0, 1'b0);

      // ReadEnable dropped during the fill; line still installed.
      access(32'h00010240, 1'b1, 1'b0);
      access(32'h00010244, 1'b0, 1'b0);

      // No request means no answer, even for a resident line.
      bus.ReadEnable  = 1'b0;
      bus.ReadAddress = 32'h00010244;
      @(negedge clk);
      check32("idle_noen_ready", 32'(bus.Ready), 32'd0);
      check32("idle_noen_instr", bus.Instruction, 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of a burst.
      a = 32'h00030040;
      bus.ReadEnable  = 1'b1;
      bus.ReadAddress = a;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         bus.MemDataReady = 1'b1;
         bus.MemDataIn    = mem_word(a + 32'(i * 4));
         @(negedge clk);
         check32("abort_req_before", 32'(bus.MemReadRequest), 32'd1);
         @(posedge clk); #1;
      end
      bus.MemDataReady = 1'b0;
      reset = 1'b0;
      #1;
      check32("abort_req", 32'(bus.MemReadRequest), 32'd0);
      check32("abort_addr", bus.MemReadAddress, 32'd0);
      check32("abort_ready", 32'(bus.Ready), 32'd0);
      check32("abort_instr", bus.Instruction, 32'd0);
      model_clear();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.ReadEnable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.MemDataReady = 1'b1;
         bus.MemDataIn    = 32'h12345678;
         @(negedge clk);
         check32("stray_beat_noreq", 32'(bus.MemReadRequest), 32'd0);
         @(posedge clk); #1;
      end
      bus.MemDataReady = 1'b0;
      access(a, 1'b0, 1'b0);
      access(32'h00010000, 1'b0, 1'b0);

      // Randomized accesses over a small footprint to force conflicts.
      for (int n = 0; n < 60; n++) begin
         a = 32'h00020000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 4)
             + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
         access(a, ($urandom_range(0, 7) == 0), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ucsbece154_icache.md
Name: ucsbece154_icache

Overview:
- Two-way set-associative, read-only instruction cache between the fetch stage and the instruction memory.
- Serves PC reads with a same-cycle hit.
- On a miss, stalls fetch and issues one block-aligned burst request to the instruction memory over the ReadRequest/ReadAddress/DataIn/DataReady bus.
- Installs the returned line into the LRU way, then returns the requested word.

Parameters:
- NUM_SETS, 8, sets per way; power of two, at least 2.
- NUM_WAYS, 2, ways per set; fixed at 2 because LRU is one bit per set.
- BLOCK_WORDS, 4, 32-bit words per line; must equal the instruction memory burst length.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ReadEnable  in  1  fetch stage requests the word at ReadAddress.
- ReadAddress  in  32  PC, word-aligned; bits [1:0] are ignored.
- Instruction  out  32  word read; valid only when Ready=1.
- Ready  out  1  Instruction valid this cycle; 0 means fetch must stall.
- MemReadRequest  out  1  burst request to instruction memory.
- MemReadAddress  out  32  block-aligned address, low log2(BLOCK_WORDS)+2 bits are zero.
- MemDataIn  in  32  burst data word.
- MemDataReady  in  1  MemDataIn is valid this cycle.

Behaviour:
- Address split:
  - offset = [OFF+1:2], where OFF = log2(BLOCK_WORDS).
  - index = next log2(NUM_SETS) bits.
  - tag = remaining upper bits.
- Storage per way and set: valid bit, tag, BLOCK_WORDS data words. One LRU bit per set names the way to replace next.
- Reset (reset=0, asynchronous):
  - All valid bits and LRU bits cleared; FSM to IDLE; word counter to 0.
  - Ready=0, Instruction=0, MemReadRequest=0, MemReadAddress=0.
  - Data arrays are not cleared.
  - Reset during a burst aborts it. Later MemDataReady pulses are ignored until a new request is issued.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - Hit (ReadEnable=1 and the valid tag of either way matches): Ready=1 combinationally, Instruction = matching word, same cycle. The LRU bit of that set is set to the other way on the clock edge.
  - Miss (ReadEnable=1, no match): Ready=0. Latch the address; choose victim = LRU way. Go to FETCH with MemReadRequest=1 and MemReadAddress = {tag,index,0} from the next cycle.
  - ReadEnable=0: Ready=0, no state change.
- FETCH:
  - MemReadRequest and MemReadAddress are held stable every cycle.
  - Each cycle with MemDataReady=1: write MemDataIn into line buffer word [counter]; counter increments.
  - Words arrive in order, offset 0 first. Cycles with MemDataReady=0 inside the burst hold the counter; gaps are legal.
  - On the cycle the final word (counter = BLOCK_WORDS-1) is captured:
    - Write the line buffer plus final word to the victim way; set valid; store tag.
    - Set the LRU bit to the non-victim way; reset the counter to 0.
    - Go to DONE. MemReadRequest=0 from the next cycle.
- DONE (exactly one cycle):
  - Ready = ReadEnable; Instruction = latched-offset word from the newly installed line.
  - The cycle ends by going to IDLE with no extra LRU update.
  - If ReadEnable=0 in DONE, Ready=0; the line remains installed.
- Fetch stage contract: ReadAddress is held constant while Ready=0 and ReadEnable=1. The cache uses its latched address during FETCH and DONE regardless.
- Miss penalty: 1 cycle request setup + memory latency + BLOCK_WORDS + 1 DONE cycle.
- Instruction is 0 whenever Ready=0.
- Both ways matching is illegal; way 0 wins.
- No writes and no invalidate port.

Decomposition:
- Shared package icache_pkg:
  - Derived widths OFF_W, IDX_W, TAG_W.
  - FSM state enum {IDLE, FETCH, DONE}.
  - BLOCK_WORDS default.
- Sub-module ucsbece154_icache_way, instantiated NUM_WAYS times:
  - Tag/valid/data arrays for one way.
  - Read port: index and offset in, hit and word out.
  - Write port: whole-line install with valid set.
- FSM, LRU bits, line buffer and counter live in the top.

Test Plan:
- Cold miss at 0x00010000: MemReadRequest=1 with MemReadAddress=0x00010000 one cycle later. After 4 DataReady beats 0xA0,0xA1,0xA2,0xA3, DONE gives Ready=1, Instruction=0xA0, and MemReadRequest=0 the cycle after the last beat.
- Subsequent reads at 0x00010004/08/0C: same-cycle Ready=1 returning 0xA1/0xA2/0xA3; MemReadRequest stays 0.
- Three addresses mapping to set 0 (0x00010000, 0x00010080, 0x00010100), with 0x00010000 re-read before the third: the third fill evicts 0x00010080. Re-reading 0x00010000 hits; re-reading 0x00010080 misses.
- Burst with DataReady pattern 1,0,1,0,0,1,1: exactly 4 words captured in order; DONE returns the offset-2 word for address 0x00010008.
- Reset driven low after 2 beats of a burst: outputs clear immediately. After release, a read of the same address misses and issues a fresh MemReadRequest.
- ReadEnable dropped to 0 during FETCH: the fill completes and DONE has Ready=0. A later read of that address hits in the same cycle.
